// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Forwarding / hazard unit for DEPTH in-flight stages after ID. Stage 0 is
//   X and stage DEPTH-1 is WB. Each issued instruction's destination and
//   remaining result latency travel down an internal shift register. For each
//   ID source operand the unit selects the youngest matching producer. A
//   source stalls when that producer is still counting down.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   issue_valid   ID instruction wants to advance into X
//   issue_wen     ID instruction writes the register file
//   issue_rd      ID destination register
//   issue_lat     advances after entering X before the result is forwardable
//   src_rs        ID source registers, source s at [s*REG_AW +: REG_AW]
//   src_used      per-source "operand is actually read"
//   hold          global pipeline freeze
//   flush_mask    per-stage kill
//   fwd_sel       per source: 0 = register file, k = forward from stage k-1
//   stall         ID must not advance (combinational)
//   stall_cycles  saturating count of cycles with stall=1 and hold=0
module hazard_scoreboard #(
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int REG_AW  = 5,
    parameter int LAT_W   = 2,
    parameter int SEL_W   = $clog2(DEPTH + 1),
    parameter int CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic                      issue_wen,
    input  logic [REG_AW-1:0]         issue_rd,
    input  logic [LAT_W-1:0]          issue_lat,
    input  logic [NUM_SRC*REG_AW-1:0] src_rs,
    input  logic [NUM_SRC-1:0]        src_used,
    input  logic                      hold,
    input  logic [DEPTH-1:0]          flush_mask,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      stall,
    output logic [CNT_W-1:0]          stall_cycles
);

    logic [DEPTH-1:0]  v_q;
    logic [DEPTH-1:0]  wen_q;
    logic [REG_AW-1:0] rd_q  [DEPTH];
    logic [LAT_W-1:0]  cnt_q [DEPTH];

    logic [DEPTH-1:0]   live;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] hit;
    logic [REG_AW-1:0]  rs_cur;

    // A flushed stage stops matching in the same cycle, so a stall caused by
    // a killed producer drops immediately.
    always_comb begin
        live = '0;
        for (int k = 0; k < DEPTH; k++) begin
            live[k] = v_q[k] & wen_q[k] & (rd_q[k] != '0) & ~flush_mask[k];
        end
    end

    // Scan from the youngest stage; the first live match decides the source
    // outcome. An older ready copy is never used behind a younger unready one.
    always_comb begin
        fwd_sel = '0;
        req     = '0;
        hit     = '0;
        rs_cur  = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            rs_cur = src_rs[s*REG_AW +: REG_AW];
            if (src_used[s] && (rs_cur != '0)) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (!hit[s] && live[k] && (rd_q[k] == rs_cur)) begin
                        hit[s] = 1'b1;
                        if (cnt_q[k] == '0) begin
                            fwd_sel[s*SEL_W +: SEL_W] = SEL_W'(k + 1);
                        end else begin
                            req[s] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign stall = issue_valid & (|req);

    // Flush is applied to the source stage before the shift, so a killed
    // entry turns into a bubble as it moves on. Under hold only the flush
    // takes effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            wen_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                rd_q[k]  <= '0;
                cnt_q[k] <= '0;
            end
        end else if (hold) begin
            v_q <= v_q & ~flush_mask;
        end else begin
            v_q[0]   <= issue_valid & ~stall;
            wen_q[0] <= issue_wen;
            rd_q[0]  <= issue_rd;
            cnt_q[0] <= issue_lat;
            for (int k = 1; k < DEPTH; k++) begin
                v_q[k]   <= v_q[k-1] & ~flush_mask[k-1];
                wen_q[k] <= wen_q[k-1];
                rd_q[k]  <= rd_q[k-1];
                cnt_q[k] <= (cnt_q[k-1] == '0) ? '0 : cnt_q[k-1] - LAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall && !hold && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: per-cycle vector table with a scoreboard
// queue of expected outputs, plus hand-written saturation and async-reset
// sequences.
module tb_hazard_scoreboard;

    localparam int NUM_SRC = 2;
    localparam int DEPTH   = 3;
    localparam int REG_AW  = 5;
    localparam int LAT_W   = 2;
    localparam int SEL_W   = 2;
    localparam int CNT_W   = 4;

    logic                      clk;
    logic                      rst;
    logic                      issue_valid;
    logic                      issue_wen;
    logic [REG_AW-1:0]         issue_rd;
    logic [LAT_W-1:0]          issue_lat;
    logic [NUM_SRC*REG_AW-1:0] src_rs;
    logic [NUM_SRC-1:0]        src_used;
    logic                      hold;
    logic [DEPTH-1:0]          flush_mask;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
    logic                      stall;
    logic [CNT_W-1:0]          stall_cycles;

    hazard_scoreboard #(
        .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .REG_AW(REG_AW),
        .LAT_W(LAT_W), .SEL_W(SEL_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_wen(issue_wen),
        .issue_rd(issue_rd), .issue_lat(issue_lat),
        .src_rs(src_rs), .src_used(src_used),
        .hold(hold), .flush_mask(flush_mask),
        .fwd_sel(fwd_sel), .stall(stall), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              iv;
        logic              wen;
        logic [REG_AW-1:0] rd;
        logic [LAT_W-1:0]  lat;
        logic [REG_AW-1:0] rs0;
        logic [REG_AW-1:0] rs1;
        logic [1:0]        used;
        logic              hold;
        logic [DEPTH-1:0]  flush;
        logic [SEL_W-1:0]  e_sel0;
        logic [SEL_W-1:0]  e_sel1;
        logic              e_stall;
        logic [CNT_W-1:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int iv, input int wen, input int rd, input int lat,
                       input int rs0, input int rs1, input int used, input int hld,
                       input int flush, input int s0, input int s1, input int st,
                       input int cnt);
        vec_t v;
        v.iv      = iv[0];
        v.wen     = wen[0];
        v.rd      = REG_AW'(rd);
        v.lat     = LAT_W'(lat);
        v.rs0     = REG_AW'(rs0);
        v.rs1     = REG_AW'(rs1);
        v.used    = 2'(used);
        v.hold    = hld[0];
        v.flush   = DEPTH'(flush);
        v.e_sel0  = SEL_W'(s0);
        v.e_sel1  = SEL_W'(s1);
        v.e_stall = st[0];
        v.e_cnt   = CNT_W'(cnt);
        vecs.push_back(v);
    endtask

    task automatic drive(input logic iv, input logic wen, input logic [REG_AW-1:0] rd,
                         input logic [LAT_W-1:0] lat, input logic [REG_AW-1:0] rs0,
                         input logic [REG_AW-1:0] rs1, input logic [1:0] used,
                         input logic hld, input logic [DEPTH-1:0] flush);
        issue_valid = iv;
        issue_wen   = wen;
        issue_rd    = rd;
        issue_lat   = lat;
        src_rs      = {rs1, rs0};
        src_used    = used;
        hold        = hld;
        flush_mask  = flush;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, '0, '0, 2'b00, 1'b0, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vec_t e;
        int   exp_cnt;

        rst = 1'b1;
        idle();
        #2;
        check("reset fwd_sel", fwd_sel, 0);
        check("reset stall", stall, 0);
        check("reset stall_cycles", stall_cycles, 0);
        @(negedge clk);
        rst = 1'b0;

        //  iv wen rd lat rs0 rs1 used hold flush | sel0 sel1 stall cnt
        // ALU back-to-back
        add(1,1, 5,0,  0, 0,2'b00,0,3'b000, 0,0,0,0);
        add(0,0, 0,0,  5, 0,2'b01,0,3'b000, 1,0,0,0);
        add(0,0, 0,0,  5, 0,2'b01,0,3'b000, 2,0,0,0);
        add(0,0, 0,0,  5, 0,2'b01,0,3'b000, 3,0,0,0);
        add(0,0, 0,0,  5, 0,2'b01,0,3'b000, 0,0,0,0);
        // load-use on source 1
        add(1,1, 7,1,  0, 0,2'b00,0,3'b000, 0,0,0,0);
        add(1,1, 8,0,  0, 7,2'b10,0,3'b000, 0,0,1,0);
        add(1,1, 8,0,  0, 7,2'b10,0,3'b000, 0,2,0,1);
        add(0,0, 0,0,  0, 0,2'b00,0,3'b000, 0,0,0,1);
        add(0,0, 0,0,  0, 0,2'b00,0,3'b000, 0,0,0,1);
        add(0,0, 0,0,  0, 0,2'b00,0,3'b000, 0,0,0,1);
        // youngest priority, both ready
        add(1,1, 3,0,  0, 0,2'b00,0,3'b000, 0,0,0,1);
        add(1,1, 3,0,  0, 0,2'b00,0,3'b000, 0,0,0,1);
        add(0,0, 0,0,  3, 0,2'b01,0,3'b000, 1,0,0,1);
        add(0,0, 0,0,  3, 0,2'b01,0,3'b000, 2,0,0,1);
        add(0,0, 0,0,  0, 0,2'b00,0,3'b000, 0,0,0,1);
        // youngest unready hides older ready copy
        add(1,1, 3,0,  0, 0,2'b00,0,3'b000, 0,0,0,1);
        add(1,1, 3,1,  0, 0,2'b00,0,3'b000, 0,0,0,1);
        add(1,1,10,0,  3, 0,2'b01,0,3'b000, 0,0,1,1);
        add(1,1,10,0,  3, 0,2'b01,0,3'b000, 2,0,0,2);
        add(0,0, 0,0,  0, 0,2'b00,0,3'b000, 0,0,0,2);
        add(0,0, 0,0,  0, 0,2'b00,0,3'b000, 0,0,0,2);
        add(0,0, 0,0,  0, 0,2'b00,0,3'b000, 0,0,0,2);
        // x0, wen=0 and unused source
        add(1,1, 0,0,  0, 0,2'b00,0,3'b000, 0,0,0,2);
        add(1,0,11,0,  0, 0,2'b11,0,3'b000, 0,0,0,2);
        add(1,1,12,1, 11, 0,2'b01,0,3'b000, 0,0,0,2);
        add(1,1,13,0,  0,12,2'b00,0,3'b000, 0,0,0,2);
        add(0,0, 0,0,  0,12,2'b10,0,3'b000, 0,2,0,2);
        add(0,0, 0,0,  0, 0,2'b00,0,3'b000, 0,0,0,2);
        add(0,0, 0,0,  0, 0,2'b00,0,3'b000, 0,0,0,2);
        // hold on an unready load
        add(1,1, 9,1,  0, 0,2'b00,0,3'b000, 0,0,0,2);
        add(1,1,14,0,  9, 0,2'b01,1,3'b000, 0,0,1,2);
        add(1,1,14,0,  9, 0,2'b01,1,3'b000, 0,0,1,2);
        add(1,1,14,0,  9, 0,2'b01,1,3'b000, 0,0,1,2);
        add(1,1,14,0,  9, 0,2'b01,0,3'b000, 0,0,1,2);
        add(1,1,14,0,  9, 0,2'b01,0,3'b000, 2,0,0,3);
        add(0,0, 0,0,  0, 0,2'b00,0,3'b000, 0,0,0,3);
        add(0,0, 0,0,  0, 0,2'b00,0,3'b000, 0,0,0,3);
        add(0,0, 0,0,  0, 0,2'b00,0,3'b000, 0,0,0,3);
        // flush under hold, then flush during shift
        add(1,1, 6,1,  0, 0,2'b00,0,3'b000, 0,0,0,3);
        add(1,1,15,0,  6, 0,2'b01,1,3'b000, 0,0,1,3);
        add(1,1,15,0,  6, 0,2'b01,1,3'b001, 0,0,0,3);
        add(1,1,15,0,  6, 0,2'b01,0,3'b000, 0,0,0,3);
        add(0,0, 0,0, 15, 0,2'b01,0,3'b000, 1,0,0,3);
        add(0,0, 0,0, 15, 0,2'b01,0,3'b010, 0,0,0,3);
        add(0,0, 0,0, 15, 0,2'b01,0,3'b000, 0,0,0,3);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v.iv, v.wen, v.rd, v.lat, v.rs0, v.rs1, v.used, v.hold, v.flush);
            exp_q.push_back(v);
            #1;
            e = exp_q.pop_front();
            check($sformatf("v%0d sel0", i), fwd_sel[SEL_W-1:0], e.e_sel0);
            check($sformatf("v%0d sel1", i), fwd_sel[2*SEL_W-1:SEL_W], e.e_sel1);
            check($sformatf("v%0d stall", i), stall, e.e_stall);
            check($sformatf("v%0d stall_cycles", i), stall_cycles, e.e_cnt);
            @(negedge clk);
        end

        // Saturation: each round is one lat-3 issue followed by three stalls.
        exp_cnt = 3;
        for (int r = 0; r < 7; r++) begin
            drive(1'b1, 1'b1, 5'd6, 2'd3, '0, '0, 2'b00, 1'b0, '0);
            #1;
            check($sformatf("sat r%0d issue stall", r), stall, 0);
            check($sformatf("sat r%0d count", r), stall_cycles, exp_cnt);
            @(negedge clk);
            for (int c = 0; c < 3; c++) begin
                drive(1'b1, 1'b0, '0, '0, 5'd6, '0, 2'b01, 1'b0, '0);
                #1;
                check($sformatf("sat r%0d c%0d stall", r, c), stall, 1);
                @(negedge clk);
            end
            exp_cnt = (exp_cnt + 3 > 15) ? 15 : exp_cnt + 3;
        end
        idle();
        #1;
        check("sat final count", stall_cycles, 15);
        @(negedge clk);

        // Async reset mid-operation
        drive(1'b1, 1'b1, 5'd4, 2'd0, '0, '0, 2'b00, 1'b0, '0);
        @(negedge clk);
        drive(1'b1, 1'b1, 5'd5, 2'd1, '0, '0, 2'b00, 1'b0, '0);
        @(negedge clk);
        drive(1'b1, 1'b0, '0, '0, 5'd4, 5'd5, 2'b11, 1'b0, '0);
        #1;
        check("pre-rst sel0", fwd_sel[SEL_W-1:0], 2);
        check("pre-rst stall", stall, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst fwd_sel", fwd_sel, 0);
        check("rst stall", stall, 0);
        check("rst stall_cycles", stall_cycles, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-rst fwd_sel", fwd_sel, 0);
        check("post-rst stall", stall, 0);
        check("post-rst stall_cycles", stall_cycles, 0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
